// File: rtl/encod_pkg.sv
// Shared types and constants for the registered 8-to-3 encoder.
// Request vectors are one-hot by intent; the index type is log2 of the request width.
package encod_pkg;

    localparam int N_IN  = 8;
    localparam int N_OUT = 3;

    typedef logic [N_IN-1:0]  req_t;
    typedef logic [N_OUT-1:0] idx_t;

    localparam idx_t IDX_NONE = 3'b000;

endpackage

// File: rtl/encoder_8_3_dat_if.sv
// Request/result bundle of the encoder: the source drives d, the encoder returns a/valid/multi.
interface encoder_8_3_dat_if;
    import encod_pkg::*;

    req_t d;
    idx_t a;
    logic valid;
    logic multi;

    modport master (output d, input a, input valid, input multi);
    modport slave  (input d, output a, output valid, output multi);

endinterface

// File: rtl/prio_enc_8_3.sv
// Combinational priority encoder: highest set request line wins.
// Also reports whether any line, or more than one line, is asserted.
module prio_enc_8_3
    import encod_pkg::*;
(
    input  req_t d,
    output idx_t idx,
    output logic any,
    output logic more
);

    idx_t idx_s;
    logic any_s;
    logic more_s;

    // Scan upward so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx_s  = IDX_NONE;
        any_s  = |d;
        // Clearing the lowest set bit leaves something only if a second bit was set.
        more_s = ((d & (d - 8'd1)) != 8'd0);
        for (int i = 0; i < N_IN; i++) begin
            if (d[i]) begin
                idx_s = idx_t'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign idx  = idx_s;
    assign any  = any_s;
    assign more = more_s;

endmodule

// File: rtl/encoder_8_3_dat.sv
// Registered 8-to-3 encoder: priority encode d and register index, valid and multi
// on every rising clock edge, with asynchronous active-low clear.
module encoder_8_3_dat
    import encod_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    encoder_8_3_dat_if.slave    bus
);

    idx_t idx_s;
    logic any_s;
    logic more_s;

    idx_t a_r;
    logic valid_r;
    logic multi_r;

    prio_enc_8_3 u_prio (
        .d    (bus.d),
        .idx  (idx_s),
        .any  (any_s),
        .more (more_s)
    );

    // Output registers; the only state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= IDX_NONE;
            valid_r <= 1'b0;
            multi_r <= 1'b0;
        end else begin
            a_r     <= idx_s;
            valid_r <= any_s;
            multi_r <= more_s;
        end
    end

    assign bus.a     = a_r;
    assign bus.valid = valid_r;
    assign bus.multi = multi_r;

endmodule

// File: tb/tb_encoder_8_3_dat.sv
// Self-checking bench for encoder_8_3_dat: directed scenarios plus randomized
// vectors compared against an arithmetic reference model.
module tb_encoder_8_3_dat;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    encoder_8_3_dat_if enc_if ();

    encoder_8_3_dat dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (enc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of highest set bit via repeated halving, counts via popcount.
    function automatic logic [4:0] model(input logic [7:0] v);
        int t;
        int top;
        int cnt;
        t   = int'(v);
        top = 0;
        while (t > 1) begin
            t   = t / 2;
            top = top + 1;
        end
        cnt = $countones(v);
        return {3'(top), (cnt > 0), (cnt > 1)};
    endfunction

    function automatic logic [4:0] observed();
        return {enc_if.a, enc_if.valid, enc_if.multi};
    endfunction

    task automatic test_reset();
        logic [4:0] got;
        rst_n    = 1'b0;
        enc_if.d = 8'b1000_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = observed();
            checks++;
            if (got !== 5'b000_0_0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got a/valid/multi=%b want 000_0_0", i, got);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 5'b111_1_0) begin
            errors++;
            $display("FAIL reset_release: got a/valid/multi=%b want 111_1_0", got);
        end
    endtask

    task automatic test_onehot_sweep();
        logic [7:0] v;
        logic [4:0] got;
        for (int i = 0; i < 8; i++) begin
            v        = 8'b0000_0001 << i;
            enc_if.d = v;
            @(posedge clk);
            #1;
            got = observed();
            checks++;
            if (got !== {3'(i), 1'b1, 1'b0} || got !== model(v)) begin
                errors++;
                $display("FAIL onehot[%0d]: got %b want %b", i, got, {3'(i), 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_zero();
        logic [4:0] got;
        enc_if.d = 8'b0000_0000;
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 5'b000_0_0) begin
            errors++;
            $display("FAIL zero_input: got %b want 000_0_0", got);
        end
        enc_if.d = 8'b0000_0001;
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 5'b000_1_0) begin
            errors++;
            $display("FAIL bit0_input: got %b want 000_1_0", got);
        end
    endtask

    task automatic test_multi_hot();
        logic [7:0] vecs [3];
        logic [4:0] exps [3];
        logic [4:0] got;
        vecs[0] = 8'b0010_0110; exps[0] = 5'b101_1_1;
        vecs[1] = 8'b1111_1111; exps[1] = 5'b111_1_1;
        vecs[2] = 8'b0000_0011; exps[2] = 5'b001_1_1;
        for (int i = 0; i < 3; i++) begin
            enc_if.d = vecs[i];
            @(posedge clk);
            #1;
            got = observed();
            checks++;
            if (got !== exps[i]) begin
                errors++;
                $display("FAIL multi_hot[%0d] d=%b: got %b want %b", i, vecs[i], got, exps[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got;
        logic [7:0] v;
        for (int i = 0; i < 6; i++) begin
            enc_if.d = 8'b0000_0001 << i;
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 5'b000_0_0) begin
            errors++;
            $display("FAIL async_clear: got %b want 000_0_0", got);
        end
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 5'b000_0_0) begin
            errors++;
            $display("FAIL async_hold: got %b want 000_0_0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 6; i < 8; i++) begin
            v        = 8'b0000_0001 << i;
            enc_if.d = v;
            @(posedge clk);
            #1;
            got = observed();
            checks++;
            if (got !== model(v)) begin
                errors++;
                $display("FAIL async_resume[%0d]: got %b want %b", i, got, model(v));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [4:0] got;
        logic [4:0] exp;
        for (int i = 0; i < 10; i++) begin
            v        = (i % 2 == 0) ? 8'b0000_1000 : 8'b0100_0000;
            exp      = (i % 2 == 0) ? 5'b011_1_0 : 5'b110_1_0;
            enc_if.d = v;
            @(posedge clk);
            #1;
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [4:0] got;
        for (int i = 0; i < 60; i++) begin
            case (i % 3)
                0:       v = 8'($urandom_range(0, 255));
                1:       v = 8'b0000_0001 << $urandom_range(0, 7);
                default: v = (8'b0000_0001 << $urandom_range(0, 7)) | (8'b0000_0001 << $urandom_range(0, 7));
            endcase
            enc_if.d = v;
            @(posedge clk);
            #1;
            got = observed();
            checks++;
            if (got !== model(v)) begin
                errors++;
                $display("FAIL random[%0d] d=%b: got %b want %b", i, v, got, model(v));
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        enc_if.d = 8'b0000_0000;
        test_reset();
        test_onehot_sweep();
        test_zero();
        test_multi_hot();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_8_3_dat.md
# encoder_8_3_dat

Registered 8-to-3 binary encoder. Accepts an 8-bit one-hot request vector `d` and produces the 3-bit index of the asserted line on `a`. It also flags whether the index is meaningful and whether the input was malformed. It sits in the combinational-circuits library as the reference encoder for one-hot select and interrupt-line vectors, and its outputs are registered so they can feed clocked logic directly.

## Interface
- `N_IN`, default 8: number of request lines. Fixed at 8 for this block.
- `N_OUT`, default 3: index width, equal to log2(`N_IN`).
- `clk` input 1: single system clock; rising edge active.
- `rst_n` input 1: reset, asynchronous and active-low.
- `d` input 8: request vector; bit i requests index i.
- `a` output 3: encoded index of the asserted request, registered.
- `valid` output 1: at least one bit of `d` was set in the sampled vector, registered.
- `multi` output 1: more than one bit of `d` was set in the sampled vector, registered.

## Operation
- Each rising `clk` edge samples `d` and updates `a`, `valid` and `multi` together.
- One-hot input (exactly one bit i set):
  - `a` = i, `valid` = 1, `multi` = 0.
  - Mapping: d=0000_0001→000, 0000_0010→001, 0000_0100→010, 0000_1000→011, 0001_0000→100, 0010_0000→101, 0100_0000→110, 1000_0000→111.
- All-zero input: `a` = 000, `valid` = 0, `multi` = 0.
- Multi-hot input:
  - Highest-index set bit wins; `a` = index of the MSB set.
  - `valid` = 1, `multi` = 1.
- `a`[2] = OR of d[7:4]; `a`[1] = OR of d[7,6,3,2]; `a`[0] = OR of d[7,5,3,1]. These equations hold for one-hot inputs only. Multi-hot inputs use the priority result above.
- No internal state beyond the output registers. Each cycle's result depends only on the `d` sampled at that edge.

## Timing
- Latency: 1 cycle. The value of `d` at edge k appears on the outputs after edge k and holds until edge k+1.
- No handshake. A new sample is taken every cycle, and `d` may change every cycle.
- Reset values: `a` = 000, `valid` = 0, `multi` = 0.
- Asserting `rst_n` low forces the reset values immediately, without waiting for `clk`, including mid-stream.
- While `rst_n` is low, outputs hold the reset values regardless of `d`.
- First capture happens at the first rising `clk` edge after `rst_n` deasserts. `rst_n` deassertion must meet recovery time relative to `clk`.
- `d` must be stable in the setup/hold window around each rising edge. `d` needs no synchronizer; it comes from the same clock domain.

## Structure
- Shared package `encod_pkg` holds:
  - `N_IN` and `N_OUT` localparams.
  - Typedefs `req_t` (logic[7:0]) and `idx_t` (logic[2:0]).
  - Constant `IDX_NONE` = 3'b000.
- One sub-module, `prio_enc_8_3`: purely combinational priority encoder producing the index, any-set and more-than-one-set signals from `d`.
- Top level contains `prio_enc_8_3` plus the three output registers with asynchronous reset.

## Test plan
- Reset: hold `rst_n`=0 with d=1000_0000 for 3 cycles → `a`=000, `valid`=0, `multi`=0 throughout. Release reset → after the next edge, `a`=111, `valid`=1.
- One-hot sweep: d=0000_0001, 0000_0010, …, 1000_0000, one per cycle → `a` = 000 through 111 in order, each one cycle after its input, with `valid`=1 and `multi`=0.
- Zero input: d=0000_0000 → `a`=000, `valid`=0, `multi`=0. Distinguish this from d=0000_0001, which gives `a`=000 with `valid`=1.
- Multi-hot:
  - d=0010_0110 → `a`=101, `valid`=1, `multi`=1.
  - d=1111_1111 → `a`=111, `multi`=1.
  - d=0000_0011 → `a`=001, `multi`=1.
- Async reset mid-stream: during the sweep, drop `rst_n` between clock edges → outputs clear to 000/0/0 before the next edge. After release, the sweep result resumes one cycle after the next edge.
- Back-to-back changes: alternate d=0000_1000 and d=0100_0000 every cycle for 10 cycles → `a` alternates 011 and 110 with exactly 1-cycle lag, with no glitch cycles.
